// File: rtl/tone_detector.sv
// Measures the period between rising edges of an asynchronous tone input and
// classifies it into one of eight melody notes, reporting a note once it is stable.
module tone_detector #(
  parameter int DIV_C      = 45977,
  parameter int DIV_D      = 40955,
  parameter int DIV_E      = 36474,
  parameter int DIV_F      = 34383,
  parameter int DIV_G      = 30612,
  parameter int DIV_A      = 27272,
  parameter int DIV_AS     = 25751,
  parameter int DIV_C5     = 22944,
  parameter int TOL_SHIFT  = 6,
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 91954,
  parameter int CNT_W      = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [3:0]       note_code,
  output logic             note_valid,
  output logic             note_strobe,
  output logic [CNT_W-1:0] period_out
);

  localparam int MW = $clog2(STABLE_CNT + 1);
  localparam int NOM [8] = '{DIV_C, DIV_D, DIV_E, DIV_F, DIV_G, DIV_A, DIV_AS, DIV_C5};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);
  localparam logic [MW-1:0]    MATCH_TOP = MW'(STABLE_CNT);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2, r_prev, r_edge;
  logic [CNT_W-1:0] r_cnt, w_period;
  logic [3:0]       r_prev_class, w_prev_class_nxt, w_class;
  logic [MW-1:0]    r_match, w_match_nxt;
  logic [3:0]       r_code, w_code_nxt;
  logic             r_valid, w_valid_nxt, r_strobe, w_strobe_nxt;
  logic [CNT_W-1:0] r_period, w_period_nxt;
  logic             w_timeout;

  // Class 0 means UNKNOWN; scanning downward lets the lowest matching note win.
  function automatic logic [3:0] classify(input logic [CNT_W-1:0] p);
    logic [3:0] c;
    int         pv;
    c  = 4'd0;
    pv = int'(p);
    for (int i = 7; i >= 0; i--) begin
      if (pv >= NOM[i] - (NOM[i] >> TOL_SHIFT) && pv <= NOM[i] + (NOM[i] >> TOL_SHIFT)) begin
        c = 4'(i + 1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  assign w_period  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  assign w_class   = classify(w_period);
  assign w_timeout = (r_state == MEASURE) && !r_edge && (w_period >= TOUT_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= tone_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 & ~r_prev;
      if (r_edge) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_prev_class <= 4'd0;
      r_match      <= '0;
      r_code       <= 4'd0;
      r_valid      <= 1'b0;
      r_strobe     <= 1'b0;
      r_period     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_class <= w_prev_class_nxt;
      r_match      <= w_match_nxt;
      r_code       <= w_code_nxt;
      r_valid      <= w_valid_nxt;
      r_strobe     <= w_strobe_nxt;
      r_period     <= w_period_nxt;
    end
  end

  // An edge coinciding with the timeout threshold is served as an edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_class_nxt = r_prev_class;
    w_match_nxt      = r_match;
    w_code_nxt       = r_code;
    w_valid_nxt      = r_valid;
    w_strobe_nxt     = 1'b0;
    w_period_nxt     = r_period;
    case (r_state)
      IDLE: begin
        if (r_edge) begin
          w_state_nxt      = MEASURE;
          w_prev_class_nxt = 4'd0;
          w_match_nxt      = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MEASURE: begin
        if (r_edge) begin
          w_period_nxt     = w_period;
          w_prev_class_nxt = w_class;
          if (w_class == 4'd0) begin
            w_match_nxt = '0;
          end else if (w_class == r_prev_class) begin
            w_match_nxt = (r_match < MATCH_TOP) ? r_match + MATCH_ONE : r_match;
          end else begin
            w_match_nxt = MATCH_ONE;
          end
          if (w_class != 4'd0 && w_match_nxt == MATCH_TOP && w_class != r_code) begin
            w_code_nxt   = w_class;
            w_valid_nxt  = 1'b1;
            w_strobe_nxt = 1'b1;
          end else begin
            w_code_nxt = r_code;
          end
        end else if (w_timeout) begin
          w_state_nxt      = IDLE;
          w_match_nxt      = '0;
          w_prev_class_nxt = 4'd0;
          if (r_code != 4'd0) begin
            w_code_nxt   = 4'd0;
            w_valid_nxt  = 1'b0;
            w_strobe_nxt = 1'b1;
          end else begin
            w_code_nxt = r_code;
          end
        end else begin
          w_state_nxt = MEASURE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign note_code   = r_code;
  assign note_valid  = r_valid;
  assign note_strobe = r_strobe;
  assign period_out  = r_period;

endmodule

// File: tb/tb_tone_detector.sv
// Self-checking bench for tone_detector with periods scaled down ~100x so that
// locks, changes and timeouts all fit in a short run.
module tb_tone_detector;

  localparam int CW   = 11;
  localparam int TOUT = 920;
  localparam int STB  = 3;
  localparam int TOL  = 6;
  localparam int LAT  = 4;  // tone_in rise to visible output, in clock cycles
  localparam int NOM [8] = '{460, 410, 365, 344, 306, 273, 258, 229};

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tone_in = 1'b0;
  logic [3:0]    note_code;
  logic          note_valid;
  logic          note_strobe;
  logic [CW-1:0] period_out;

  tone_detector #(
    .DIV_C(460), .DIV_D(410), .DIV_E(365), .DIV_F(344),
    .DIV_G(306), .DIV_A(273), .DIV_AS(258), .DIV_C5(229),
    .TOL_SHIFT(TOL), .STABLE_CNT(STB), .TIMEOUT(TOUT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in),
    .note_code(note_code), .note_valid(note_valid),
    .note_strobe(note_strobe), .period_out(period_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;    // 0 = hold the line low long enough to time out
    int edges;
    int exp_code;
    int exp_strb;
  } vec_t;

  vec_t tbl [10];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int strobes = 0;
  int pend [$];   // cycle at which each pending rising edge was driven
  int hist [$];   // classes of the periods measured in the current session
  int last_d;
  bit in_sess    = 1'b0;
  bit in_reset   = 1'b0;
  int exp_code   = 0;
  int exp_period = 0;
  bit exp_strobe = 1'b0;

  function automatic int classify(int p);
    for (int i = 0; i < 8; i++) begin
      if (p >= NOM[i] - (NOM[i] >> TOL) && p <= NOM[i] + (NOM[i] >> TOL)) return i + 1;
    end
    return 0;
  endfunction

  // A note is reported once the last STB periods of the session agree on it.
  function automatic void model_edge(int d);
    if (!in_sess) begin
      in_sess = 1'b1;
      hist.delete();
    end else begin
      int g;
      int cls;
      bit same;
      g = d - last_d;
      cls = classify(g);
      exp_period = g;
      hist.push_back(cls);
      if (cls != 0 && hist.size() >= STB) begin
        same = 1'b1;
        for (int k = hist.size() - STB; k < hist.size(); k++) if (hist[k] != cls) same = 1'b0;
        if (same && cls != exp_code) begin
          exp_code   = cls;
          exp_strobe = 1'b1;
        end
      end
    end
    last_d = d;
  endfunction

  function automatic void model_timeout();
    in_sess = 1'b0;
    if (exp_code != 0) begin
      exp_code   = 0;
      exp_strobe = 1'b1;
    end
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all(string name);
    vectors++;
    if ({note_code, note_valid, note_strobe, period_out} !==
        {4'(exp_code), (exp_code != 0), exp_strobe, CW'(exp_period)}) begin
      errors++;
      $display("FAIL %s cycle %0d: code=%0d valid=%0b strobe=%0b period=%0d, expected code=%0d valid=%0b strobe=%0b period=%0d",
               name, cyc, note_code, note_valid, note_strobe, period_out,
               exp_code, (exp_code != 0), exp_strobe, exp_period);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    exp_strobe = 1'b0;
    if (!in_reset) begin
      if (pend.size() > 0 && pend[0] + LAT == cyc) model_edge(pend.pop_front());
      else if (in_sess && cyc == last_d + TOUT + LAT) model_timeout();
    end
    if (note_strobe) strobes++;
    compare_all("cycle");
  endtask

  task automatic run_tone(int p, int n);
    repeat (n) begin
      tone_in = 1'b1;
      pend.push_back(cyc);
      repeat (p / 2) step();
      tone_in = 1'b0;
      repeat (p - p / 2) step();
    end
  endtask

  task automatic silence(int n);
    tone_in = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset(int cycles, bit toggle);
    #2;
    rst_n = 1'b0;
    in_reset = 1'b1;
    pend.delete();
    hist.delete();
    in_sess = 1'b0;
    exp_code = 0;
    exp_period = 0;
    exp_strobe = 1'b0;
    #1;
    compare_all("reset_immediate");
    repeat (cycles) begin
      step();
      if (toggle) tone_in = ~tone_in;
    end
    tone_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    int s0;
    tbl[0] = '{273, 4, 6, 1};    // lock on A from silence
    tbl[1] = '{344, 3, 6, 0};    // two F periods: A still reported
    tbl[2] = '{344, 1, 4, 1};    // third F period: switch to F
    tbl[3] = '{277, 4, 6, 1};    // upper window bound of A
    tbl[4] = '{278, 10, 6, 0};   // just outside A: note holds
    tbl[5] = '{0, 0, 0, 1};      // timeout drops the note
    tbl[6] = '{278, 10, 0, 0};   // outside window from silence: nothing
    tbl[7] = '{0, 0, 0, 0};      // timeout with no note: no strobe
    tbl[8] = '{229, 4, 8, 1};    // C5 lock
    tbl[9] = '{0, 0, 0, 1};

    // Reset with a toggling input, then two quiet cycles
    do_reset(6, 1'b1);
    step();
    step();

    // Lock on A: period visible after the second edge, note after the fourth
    run_tone(273, 2);
    check("lockA_period", int'(period_out), 273);
    check("lockA_early_code", int'(note_code), 0);
    run_tone(273, 2);
    check("lockA_code", int'(note_code), 6);
    silence(TOUT + 10);

    for (int r = 0; r < 10; r++) begin
      s0 = strobes;
      if (tbl[r].period == 0) silence(TOUT + 10);
      else run_tone(tbl[r].period, tbl[r].edges);
      check($sformatf("row%0d_code", r), int'(note_code), tbl[r].exp_code);
      check($sformatf("row%0d_strobes", r), strobes - s0, tbl[r].exp_strb);
    end

    // Edge exactly at the timeout threshold counts as an edge
    run_tone(460, 3);
    run_tone(TOUT, 1);
    check("edge_at_timeout_code", int'(note_code), 1);
    run_tone(460, 2);
    check("edge_at_timeout_period", int'(period_out), 460);
    s0 = strobes;
    silence(TOUT + 10);
    check("timeout_code", int'(note_code), 0);
    check("timeout_valid", int'(note_valid), 0);
    check("timeout_period_hold", int'(period_out), 460);
    check("timeout_strobes", strobes - s0, 1);
    run_tone(229, 4);
    check("relock_c5", int'(note_code), 8);

    // One cycle past the threshold: timeout first, then a fresh session
    run_tone(273, 3);
    run_tone(TOUT + 1, 1);
    run_tone(273, 4);
    check("after_late_edge_code", int'(note_code), 6);
    silence(TOUT + 10);

    // Asynchronous reset between edges while locked on G
    run_tone(306, 4);
    check("lockG_code", int'(note_code), 5);
    do_reset(3, 1'b0);
    run_tone(306, 3);
    check("relock_needs_4_edges", int'(note_code), 0);
    run_tone(306, 1);
    check("relock_G", int'(note_code), 5);

    // Random notes with jitter, off-grid periods and gaps
    for (int it = 0; it < 25; it++) begin
      int sel;
      int p;
      sel = int'($urandom_range(0, 9));
      if (sel == 9) begin
        silence(int'($urandom_range(100, TOUT + 50)));
      end else begin
        if (sel == 8) p = int'($urandom_range(200, 500));
        else p = NOM[sel] + int'($urandom_range(0, 8)) - 4;
        run_tone(p, int'($urandom_range(1, 5)));
      end
    end
    silence(TOUT + 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Receive-side counterpart of the note generator. Measures the period of an incoming square-wave tone, such as the speaker line, and classifies it into one of the eight melody notes or silence.
- Reports a note only after it has been stable for several periods, with a strobe on every change.
- Used for loop-back self-test of the tone path and as a note decoder feeding display/debug logic.

Parameters:
- DIV_C, 45977, nominal full period in clk cycles for C4 (261 Hz at 12 MHz)
- DIV_D, 40955, D4 period
- DIV_E, 36474, E4 period
- DIV_F, 34383, F4 period
- DIV_G, 30612, G4 period
- DIV_A, 27272, A4 period
- DIV_AS, 25751, A#4 period
- DIV_C5, 22944, C5 period
- TOL_SHIFT, 6, match window = nominal ± (nominal >> TOL_SHIFT)
- STABLE_CNT, 3, consecutive matching periods required to report a note (≥1)
- TIMEOUT, 91954, clk cycles without an edge before declaring silence
- CNT_W, 17, period counter width; must hold TIMEOUT

Ports:
- clk  in  1  system clock, 12 MHz
- rst_n  in  1  asynchronous active-low reset
- tone_in  in  1  asynchronous square-wave input
- note_code  out  4  0=silence, 1=C, 2=D, 3=E, 4=F, 5=G, 6=A, 7=A#, 8=C5
- note_valid  out  1  high while note_code≠0
- note_strobe  out  1  one-cycle pulse when note_code changes
- period_out  out  CNT_W  last measured period in clk cycles

Behaviour:
- Reset: all outputs 0, synchronizer flops 0, counter 0, state IDLE.
  - Reset is asynchronous: assertion clears everything immediately, mid-lock or mid-measurement included.
- Input path: 2-flop synchronizer, then a registered rising-edge detect. Only rising edges are used; duty cycle is ignored.
- Period: number of clk cycles between consecutive detected rising edges. Example: edges at cycles 10 and 110 → 100.
- Counter:
  - Clears on a detected edge, then increments each cycle.
  - Saturates at 2^CNT_W−1; no wrap.
- States:
  - IDLE: no reference edge. A detected edge → MEASURE with counter started; no period is produced.
  - MEASURE: on each detected edge, period_out ← period (visible next cycle), then the period is classified.
    - Class = the note whose window contains the period, window bounds inclusive.
    - Windows are non-overlapping at defaults. If a period falls in two windows, the lowest note code wins.
    - No window match → class UNKNOWN.
- Match counter:
  - Class equals the previous class and is not UNKNOWN → increment, saturating at STABLE_CNT.
  - Otherwise → set to 1, or to 0 when UNKNOWN.
  - When the counter reaches STABLE_CNT and the class differs from note_code: note_code ← class, note_valid ← 1, note_strobe pulses. All three take effect the cycle after the edge.
  - UNKNOWN periods never change note_code; the reported note holds.
- Timeout:
  - Counter reaching TIMEOUT with no edge → state IDLE, match counter 0.
  - If note_code≠0: note_code ← 0, note_valid ← 0, note_strobe pulses.
  - period_out holds its last value.
- A detected edge in the same cycle the counter hits TIMEOUT counts as an edge; the timeout is ignored.
- Re-lock after silence requires STABLE_CNT+1 edges.
- note_strobe never stays high for more than one cycle.
- A repeated identical note never re-strobes.

Test Plan:
- Reset: rst_n low during toggling tone_in → note_code=0, note_valid=0, note_strobe=0, period_out=0; remains so for 2 cycles after release with tone_in static.
- Lock on A: tone_in period 27272, 4 rising edges → period_out=27272 after the 2nd edge. note_code=6, note_valid=1 and one note_strobe pulse appear exactly one cycle after the 4th detected edge, not earlier.
- Window edges: period 27698 (27272+426) ×4 → note_code=6. Period 27699 ×10 from silence → note_code stays 0, no strobe.
- Change: locked on A, switch to period 34383 → note_code stays 6 for two F periods, becomes 4 after the third, single strobe.
- Timeout: locked on C (45977), hold tone_in low → 91954 cycles after the last edge note_code=0, note_valid=0, one strobe, period_out=45977. A new 22944 tone re-locks to 8 after 4 edges.
- Async reset mid-lock: rst_n pulsed low between edges while note_code=5 → outputs 0 immediately, no strobe. After release, 4 edges are needed to re-lock.
